// File: rtl/i_cache_pkg.sv
// rtl/i_cache_pkg.sv - shared i-cache geometry constants and data-arbiter state type
package i_cache_pkg;

  localparam int ICACHE_ADDR_WIDTH   = 4;
  localparam int ICACHE_DATA_WIDTH   = 256;
  localparam int ICACHE_BEAT_WIDTH   = 32;
  localparam int ICACHE_NUM_BEATS    = ICACHE_DATA_WIDTH / ICACHE_BEAT_WIDTH;
  localparam int ICACHE_NUM_WMASKS   = ICACHE_DATA_WIDTH / 8;
  localparam int ICACHE_STARVE_LIMIT = 4;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } darb_state_t;

endpackage

// File: rtl/i_cache_beat_mask_gen.sv
// rtl/i_cache_beat_mask_gen.sv - beat index to SRAM byte mask and lane-replicated write data
module i_cache_beat_mask_gen
  import i_cache_pkg::*;
#(
  parameter int DATA_WIDTH = ICACHE_DATA_WIDTH,
  parameter int BEAT_WIDTH = ICACHE_BEAT_WIDTH,
  parameter int CNT_W      = ((DATA_WIDTH / BEAT_WIDTH) > 1) ? $clog2(DATA_WIDTH / BEAT_WIDTH) : 1
) (
  input  logic [CNT_W-1:0]        beat_cnt,
  input  logic [BEAT_WIDTH-1:0]   beat_data,
  output logic [DATA_WIDTH/8-1:0] wmask,
  output logic [DATA_WIDTH-1:0]   din
);

  localparam int NUM_BEATS  = DATA_WIDTH / BEAT_WIDTH;
  localparam int NUM_WMASKS = DATA_WIDTH / 8;
  localparam int BEAT_BYTES = BEAT_WIDTH / 8;

  // Bytes of beat lane 0; shifted up to the lane the beat lands in.
  localparam logic [NUM_WMASKS-1:0] LANE_MASK = {NUM_WMASKS{1'b1}} >> (NUM_WMASKS - BEAT_BYTES);

  assign wmask = LANE_MASK << (BEAT_BYTES * int'(beat_cnt));
  assign din   = {NUM_BEATS{beat_data}};

endmodule

// File: rtl/i_cache_data_arbiter.sv
// rtl/i_cache_data_arbiter.sv - shares the i-cache data SRAM RW port between fetch reads and refill beats (option: I_CACHE_DARB_STARVE_GUARD_EN)
module i_cache_data_arbiter
  import i_cache_pkg::*;
#(
  parameter int ADDR_WIDTH   = ICACHE_ADDR_WIDTH,
  parameter int DATA_WIDTH   = ICACHE_DATA_WIDTH,
  parameter int BEAT_WIDTH   = ICACHE_BEAT_WIDTH,
  parameter int NUM_BEATS    = DATA_WIDTH / BEAT_WIDTH,
  parameter int NUM_WMASKS   = DATA_WIDTH / 8,
  parameter int STARVE_LIMIT = ICACHE_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fe_req,
  input  logic [ADDR_WIDTH-1:0] fe_addr,
  output logic                  fe_gnt,
  output logic                  fe_rvalid,
  output logic [DATA_WIDTH-1:0] fe_rdata,
  input  logic                  rf_valid,
  input  logic [ADDR_WIDTH-1:0] rf_index,
  input  logic [BEAT_WIDTH-1:0] rf_data,
  output logic                  rf_ready,
  output logic                  rf_done,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  localparam int CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  darb_state_t           state_q, state_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [ADDR_WIDTH-1:0] fill_idx_q, fill_idx_d;
  logic                  fe_rvalid_q, fe_rvalid_d;
  logic                  rf_done_q, rf_done_d;

  logic                  beat_acc;
  logic                  block;
  logic                  force_gnt;
  logic [NUM_WMASKS-1:0] gen_wmask;
  logic [DATA_WIDTH-1:0] gen_din;

`ifdef I_CACHE_DARB_STARVE_GUARD_EN
  localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);
  logic [SCNT_W-1:0] starve_cnt_q, starve_cnt_d;

  // A fetch that has lost to refill beats STARVE_LIMIT times in a row gets one stolen cycle.
  assign force_gnt = (starve_cnt_q == SCNT_W'(STARVE_LIMIT));

  // Count only denials caused by a beat; a blocked fetch must wait for the line anyway.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!fe_req || fe_gnt || force_gnt) begin
      starve_cnt_d = '0;
    end else if (beat_acc && !block) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign force_gnt = 1'b0;
`endif

  // Refill wins the port; a fetch to the line currently being filled is held off.
  assign rf_ready = rst_n & ~force_gnt;
  assign beat_acc = rf_valid & rf_ready;
  assign block    = (state_q == FILL) && (fe_addr == fill_idx_q);
  assign fe_gnt   = rst_n & fe_req & ~beat_acc & ~block;

  i_cache_beat_mask_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .BEAT_WIDTH (BEAT_WIDTH),
    .CNT_W      (CNT_W)
  ) u_mask_gen (
    .beat_cnt  (beat_cnt_q),
    .beat_data (rf_data),
    .wmask     (gen_wmask),
    .din       (gen_din)
  );

  // SRAM pin drive: beat write, fetch read, or deselected with quiet pins.
  always_comb begin
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_wmask0 = '0;
    sram_addr0  = '0;
    sram_din0   = '0;
    if (beat_acc) begin
      sram_csb0   = 1'b0;
      sram_web0   = 1'b0;
      sram_addr0  = (state_q == FILL) ? fill_idx_q : rf_index;
      sram_wmask0 = gen_wmask;
      sram_din0   = gen_din;
    end else if (fe_gnt) begin
      sram_csb0  = 1'b0;
      sram_addr0 = fe_addr;
    end
  end

  // Beat sequencing: first beat latches the line index, last beat closes the line.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    fill_idx_d  = fill_idx_q;
    fe_rvalid_d = fe_gnt;
    rf_done_d   = 1'b0;
    if (beat_acc) begin
      if (beat_cnt_q == LAST_BEAT) begin
        state_d    = IDLE;
        beat_cnt_d = '0;
        rf_done_d  = 1'b1;
      end else begin
        if (state_q == IDLE) begin
          fill_idx_d = rf_index;
        end
        state_d    = FILL;
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      fill_idx_q  <= '0;
      fe_rvalid_q <= 1'b0;
      rf_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      fill_idx_q  <= fill_idx_d;
      fe_rvalid_q <= fe_rvalid_d;
      rf_done_q   <= rf_done_d;
    end
  end

  assign fe_rvalid = fe_rvalid_q;
  assign rf_done   = rf_done_q;
  assign fe_rdata  = sram_dout0;

  // The refill owner must hold the line index for the whole line.
  a_rf_index_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (beat_acc && state_q == FILL) |-> (rf_index == fill_idx_q));

endmodule

// File: tb/tb_i_cache_data_arbiter.sv
// tb/tb_i_cache_data_arbiter.sv - scoreboard bench for the i-cache data arbiter with an SRAM model
module tb_i_cache_data_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fe_req;
  logic [3:0]   fe_addr;
  logic         fe_gnt;
  logic         fe_rvalid;
  logic [255:0] fe_rdata;
  logic         rf_valid;
  logic [3:0]   rf_index;
  logic [31:0]  rf_data;
  logic         rf_ready;
  logic         rf_done;
  logic         sram_csb0;
  logic         sram_web0;
  logic [31:0]  sram_wmask0;
  logic [3:0]   sram_addr0;
  logic [255:0] sram_din0;
  logic [255:0] sram_dout0;

  i_cache_data_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fe_req      (fe_req),
    .fe_addr     (fe_addr),
    .fe_gnt      (fe_gnt),
    .fe_rvalid   (fe_rvalid),
    .fe_rdata    (fe_rdata),
    .rf_valid    (rf_valid),
    .rf_index    (rf_index),
    .rf_data     (rf_data),
    .rf_ready    (rf_ready),
    .rf_done     (rf_done),
    .sram_csb0   (sram_csb0),
    .sram_web0   (sram_web0),
    .sram_wmask0 (sram_wmask0),
    .sram_addr0  (sram_addr0),
    .sram_din0   (sram_din0),
    .sram_dout0  (sram_dout0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   addr;
    logic [31:0]  wmask;
    logic [255:0] din;
  } wr_t;

  logic [255:0] rd_q[$];
  wr_t          wr_q[$];
  int           done_q[$];
  int           n_chk  = 0;
  int           n_fail = 0;

  logic [31:0] wm_tbl [8] = '{32'h0000000F, 32'h000000F0, 32'h00000F00, 32'h0000F000,
                              32'h000F0000, 32'h00F00000, 32'h0F000000, 32'hF0000000};

  localparam logic [255:0] LINE5 =
    256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111;
  localparam logic [255:0] LINE12 =
    256'hB0000007_B0000006_B0000005_B0000004_B0000003_B0000002_B0000001_B0000000;

  function automatic logic [255:0] line_init(input int i);
    logic [255:0] l;
    for (int j = 0; j < 8; j++) l[32*j +: 32] = 32'hC0000000 | (32'(i) << 8) | 32'(j);
    return l;
  endfunction

  // Single-port SRAM model: one-cycle read latency, byte-masked writes.
  logic [255:0] mem [16];
  logic         loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= line_init(i);
      loaded <= 1'b1;
    end else if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int b = 0; b < 32; b++)
          if (sram_wmask0[b]) mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
      end else begin
        sram_dout0 <= mem[sram_addr0];
      end
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fe_req = 1'b0; fe_addr = 4'd0; rf_valid = 1'b0; rf_index = 4'd0; rf_data = 32'd0;
  endtask

  task automatic beat(input logic [3:0] idx, input int b, input logic [31:0] d);
    wr_t w;
    rf_valid = 1'b1; rf_index = idx; rf_data = d;
    w.addr = idx; w.wmask = wm_tbl[b]; w.din = {8{d}};
    wr_q.push_back(w);
    if (b == 7) done_q.push_back(1);
  endtask

  // Monitor: compares every read return, SRAM write and refill completion against the queues.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (fe_rvalid) begin
        if (rd_q.size() == 0) chk("fe_rvalid_unexpected", 256'(fe_rvalid), 256'd0);
        else chk("fe_rdata", fe_rdata, rd_q.pop_front());
      end
      if (!sram_csb0 && !sram_web0) begin
        if (wr_q.size() == 0) chk("sram_write_unexpected", 256'(sram_web0), 256'd1);
        else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("sram_addr0_wr", 256'(sram_addr0), 256'(w.addr));
          chk("sram_wmask0", 256'(sram_wmask0), 256'(w.wmask));
          chk("sram_din0", sram_din0, w.din);
        end
      end
      if (rf_done) begin
        if (done_q.size() == 0) chk("rf_done_unexpected", 256'(rf_done), 256'd0);
        else void'(done_q.pop_front());
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_csb"}, 256'(sram_csb0), 256'd1);
    chk({tag, "_web"}, 256'(sram_web0), 256'd1);
    chk({tag, "_fe_gnt"}, 256'(fe_gnt), 256'd0);
    chk({tag, "_rf_ready"}, 256'(rf_ready), 256'd0);
    chk({tag, "_fe_rvalid"}, 256'(fe_rvalid), 256'd0);
    chk({tag, "_rf_done"}, 256'(rf_done), 256'd0);
  endtask

  initial begin
    int  nb;
    logic starve;

    // Reset with both requesters active: nothing may reach the SRAM.
    rst_n = 1'b0;
    idle_inputs();
    fe_req = 1'b1; fe_addr = 4'd3; rf_valid = 1'b1; rf_index = 4'd5;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    step();
    rst_n = 1'b1;

    // Fetch of preloaded line 3.
    idle_inputs();
    fe_req = 1'b1; fe_addr = 4'd3;
    rd_q.push_back(line_init(3));
    @(negedge clk);
    chk("rd3_fe_gnt", 256'(fe_gnt), 256'd1);
    chk("rd3_csb", 256'(sram_csb0), 256'd0);
    chk("rd3_web", 256'(sram_web0), 256'd1);
    chk("rd3_addr", 256'(sram_addr0), 256'd3);
    step();
    idle_inputs();
    step();

    // Refill line 5, beats 0..3 with a fetch to the same line pending.
    for (int b = 0; b < 4; b++) begin
      beat(4'd5, b, 32'h11111111 * 32'(b + 1));
      fe_req = 1'b1; fe_addr = 4'd5;
      @(negedge clk);
      chk("fill5_rf_ready", 256'(rf_ready), 256'd1);
      chk("fill5_fe_gnt_beat", 256'(fe_gnt), 256'd0);
      step();
    end
    // Gap: same line blocked, a different line is granted.
    rf_valid = 1'b0;
    @(negedge clk);
    chk("fill5_fe_gnt_block", 256'(fe_gnt), 256'd0);
    step();
    fe_addr = 4'd9;
    rd_q.push_back(line_init(9));
    @(negedge clk);
    chk("fill5_fe_gnt_other", 256'(fe_gnt), 256'd1);
    step();
    for (int b = 4; b < 8; b++) begin
      beat(4'd5, b, 32'h11111111 * 32'(b + 1));
      fe_req = 1'b1; fe_addr = 4'd5;
      @(negedge clk);
      chk("fill5_fe_gnt_beat", 256'(fe_gnt), 256'd0);
      step();
    end
    // Cycle after the last beat: done pulse, and the same line is readable.
    rf_valid = 1'b0;
    rd_q.push_back(LINE5);
    @(negedge clk);
    chk("fill5_rf_done", 256'(rf_done), 256'd1);
    chk("fill5_fe_gnt_after", 256'(fe_gnt), 256'd1);
    step();
    idle_inputs();
    @(negedge clk);
    chk("fill5_rf_done_pulse", 256'(rf_done), 256'd0);
    step();

    // Contention: fetch to line 7 and refill of line 2 every cycle.
    nb = 0;
    for (int c = 0; c < 5; c++) begin
      starve = 1'b0;
`ifdef I_CACHE_DARB_STARVE_GUARD_EN
      starve = (c == 4);
`endif
      fe_req = 1'b1; fe_addr = 4'd7;
      rf_valid = 1'b1; rf_index = 4'd2; rf_data = 32'h20000000 | 32'(nb);
      if (starve) rd_q.push_back(line_init(7));
      else begin
        beat(4'd2, nb, 32'h20000000 | 32'(nb));
        nb++;
      end
      @(negedge clk);
      chk("cont_rf_ready", 256'(rf_ready), 256'(!starve));
      chk("cont_fe_gnt", 256'(fe_gnt), 256'(starve));
      step();
    end
    fe_req = 1'b0;
    while (nb < 8) begin
      beat(4'd2, nb, 32'h20000000 | 32'(nb));
      nb++;
      step();
    end
    idle_inputs();
    repeat (2) step();

    // Partial refill of line 12, then reset mid-line.
    for (int b = 0; b < 3; b++) begin
      beat(4'd12, b, 32'hDEAD0000 | 32'(b));
      fe_req = 1'b1; fe_addr = 4'd4;
      @(negedge clk);
      chk("part12_fe_gnt", 256'(fe_gnt), 256'd0);
      step();
    end
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midfill_reset");
    repeat (2) step();
    idle_inputs();
    rst_n = 1'b1;

    // Fresh refill of line 12 must start from beat 0.
    for (int b = 0; b < 8; b++) begin
      beat(4'd12, b, 32'hB0000000 | 32'(b));
      if (b == 0) begin
        @(negedge clk);
        chk("refill12_first_wmask", 256'(sram_wmask0), 256'h0000000F);
        chk("refill12_first_addr", 256'(sram_addr0), 256'd12);
      end
      step();
    end
    rf_valid = 1'b0;
    fe_req = 1'b1; fe_addr = 4'd12;
    rd_q.push_back(LINE12);
    @(negedge clk);
    chk("refill12_rf_done", 256'(rf_done), 256'd1);
    chk("refill12_fe_gnt", 256'(fe_gnt), 256'd1);
    step();
    idle_inputs();
    repeat (3) step();

    chk("rd_q_drained", 256'(rd_q.size()), 256'd0);
    chk("wr_q_drained", 256'(wr_q.size()), 256'd0);
    chk("done_q_drained", 256'(done_q.size()), 256'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i_cache_data_arbiter.md
Name: i_cache_data_arbiter

Overview:
Sequences and shares the single RW port of the 16x256 i-cache data SRAM between two requesters. The fetch path issues whole-line reads. The refill path delivers a line as 8 x 32-bit beats, which the block writes with byte masks. Sits between the i-cache controller/refill FSM and the SRAM macro. Owns the SRAM control pins, read-data valid timing, and refill beat sequencing.

Parameters:
ADDR_WIDTH, 4, line index width (16 lines)
DATA_WIDTH, 256, SRAM line width
BEAT_WIDTH, 32, refill beat width
NUM_BEATS, DATA_WIDTH/BEAT_WIDTH (8), beats per line
NUM_WMASKS, DATA_WIDTH/8 (32), SRAM byte-mask width
STARVE_LIMIT, 4, consecutive denied fetch cycles before forced fetch grant (optional feature only)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
fe_req  in  1  fetch read request
fe_addr  in  ADDR_WIDTH  fetch line index
fe_gnt  out  1  fetch request accepted this cycle (combinational)
fe_rvalid  out  1  fe_rdata valid (registered)
fe_rdata  out  DATA_WIDTH  read line (passthrough of sram_dout0)
rf_valid  in  1  refill beat valid
rf_index  in  ADDR_WIDTH  refill line index; held constant across one line
rf_data  in  BEAT_WIDTH  refill beat payload
rf_ready  out  1  beat accepted when rf_valid & rf_ready (combinational)
rf_done  out  1  one-cycle pulse after the last beat is accepted (registered)
sram_csb0  out  1  SRAM chip select, active low
sram_web0  out  1  SRAM write enable, active low
sram_wmask0  out  NUM_WMASKS  SRAM byte mask
sram_addr0  out  ADDR_WIDTH  SRAM address
sram_din0  out  DATA_WIDTH  SRAM write data
sram_dout0  in  DATA_WIDTH  SRAM read data

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: state IDLE, beat_cnt 0, fill_idx 0, fe_rvalid 0, rf_done 0, starve_cnt 0.
- While rst_n is low, combinational outputs resolve to: sram_csb0 1, sram_web0 1, fe_gnt 0, rf_ready 0.
- States:
  - IDLE: no line being refilled.
  - FILL: fill_idx latched, beat_cnt counts accepted beats.
- Transitions:
  - IDLE->FILL on the first accepted beat when NUM_BEATS>1; latch fill_idx=rf_index, beat_cnt=1.
  - FILL: each accepted beat increments beat_cnt.
  - The accepted beat with beat_cnt==NUM_BEATS-1 returns to IDLE and clears beat_cnt.
- Arbitration, evaluated each cycle:
  - Refill has priority: rf_ready = 1 whenever not in reset (subject to the optional feature).
  - fe_gnt = fe_req & !(rf_valid & rf_ready) & !block.
  - block = (state==FILL) & (fe_addr==fill_idx). This prevents reads of a partially written line.
- SRAM drive for an accepted beat:
  - sram_csb0=0, sram_web0=0, sram_addr0 = fill_idx (rf_index in IDLE).
  - sram_din0 = rf_data replicated across all beat lanes.
  - sram_wmask0 = 4'hF << (4*beat_cnt).
- SRAM drive for a fetch grant: sram_csb0=0, sram_web0=1, sram_addr0=fe_addr, sram_wmask0=0.
- Otherwise: sram_csb0=1, sram_web0=1, other SRAM pins 0.
- Read latency: grant in cycle N gives fe_rvalid=1 in cycle N+1, with fe_rdata = sram_dout0 in that cycle. fe_rdata is undefined when fe_rvalid=0.
- Write commit: the SRAM writes mem one edge after the beat is accepted.
- rf_done: registered, high in cycle N+1 for a last beat accepted in cycle N. A fetch to the same index may be granted in cycle N+1 and returns the fully written line.
- Simultaneous events:
  - Fetch and beat in the same cycle: the beat wins and the fetch retries.
  - Fetch to a different index during FILL may be granted in any cycle without a beat.
- Reset mid-FILL: the line is left partially written and rf_done is never pulsed. The refill owner must keep that line's tag invalid.
- rf_index change during FILL: illegal. The block uses fill_idx; assertion fires in simulation.

Optional Feature:
I_CACHE_DARB_STARVE_GUARD_EN
- Defined:
  - starve_cnt increments each cycle fe_req=1 and the fetch is denied only because of a beat (not block).
  - starve_cnt clears on fe_gnt or when fe_req=0.
  - When starve_cnt==STARVE_LIMIT, rf_ready=0 for one cycle, the fetch is granted and starve_cnt clears.
- Undefined: strict refill priority; starve_cnt is absent.

Decomposition:
- Package i_cache_pkg:
  - ICACHE_ADDR_WIDTH, ICACHE_DATA_WIDTH, ICACHE_BEAT_WIDTH, ICACHE_NUM_BEATS, ICACHE_NUM_WMASKS
  - typedef enum {IDLE, FILL} darb_state_t
- Sub-module i_cache_beat_mask_gen: beat_cnt -> sram_wmask0 and lane-replicated sram_din0. Purely combinational, shared with the future d-cache.

Test Plan:
- Reset, then fe_req=1, fe_addr=3 with a preloaded line -> fe_gnt same cycle, fe_rvalid next cycle, fe_rdata = line 3.
- 8 back-to-back beats 0x11111111..0x88888888 to index 5 -> wmask 0x0000000F..0xF0000000 in order, rf_done one cycle after beat 8; a read of index 5 returns the beats packed low to high.
- During FILL of index 5, fe_req to index 5 -> fe_gnt=0 until the cycle after the last beat. fe_req to index 9 in a gap cycle -> granted.
- fe_req and rf_valid both asserted every cycle -> rf_ready=1, fe_gnt=0. With the macro defined and STARVE_LIMIT=4, the fetch is granted on cycle 5 with rf_ready=0.
- Assert rst_n=0 after beat 3 -> all outputs take reset values immediately. After release, a new refill starts with beat_cnt 0 and wmask 0x0000000F.
